// File: rtl/cska_stage_pkg.sv
// Shared constants and the result record for the carry-skip adder operand/result stage.
package cska_stage_pkg;

  localparam int WIDTH_C = 24;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_ACC = 1'b1;

  typedef struct packed {
    logic             op;
    logic             ovf;
    logic [WIDTH_C:0] sum;
  } res_t;

endpackage

// File: rtl/cska_res_fifo.sv
// First-word-fall-through result FIFO; a push into a full FIFO is accepted only alongside a pop.
module cska_res_fifo
  import cska_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  res_t push_data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output res_t pop_data_o
);

  localparam int PW = $clog2(DEPTH);

  res_t          mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW:0]   count_q, count_d;
  logic          doPush, doPop;

  assign full_o     = (count_q == (PW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign pop_data_o = mem_q[rdPtr_q];
  assign doPop      = pop_i && !empty_o;
  assign doPush     = push_i && (!full_o || doPop);

  always_comb begin
    wrPtr_d = doPush ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d = doPop ? rdPtr_q + 1'b1 : rdPtr_q;
    count_d = count_q;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      if (doPush) mem_q[wrPtr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/h_u_cska24.sv
// 24-bit unsigned carry-skip adder built from six 4-bit ripple blocks.
module h_u_cska24 (
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic [24:0] out
);

  logic carry;
  logic rip;

  // A block whose bits all propagate passes its incoming carry straight through.
  always_comb begin
    carry = 1'b0;
    rip   = 1'b0;
    out   = '0;
    for (int blk = 0; blk < 6; blk++) begin
      rip = carry;
      for (int i = 0; i < 4; i++) begin
        out[blk*4+i] = a[blk*4+i] ^ b[blk*4+i] ^ rip;
        rip = (a[blk*4+i] & b[blk*4+i]) | (rip & (a[blk*4+i] ^ b[blk*4+i]));
      end
      carry = (&(a[blk*4 +: 4] ^ b[blk*4 +: 4])) ? carry : rip;
    end
    out[24] = carry;
  end

endmodule

// File: rtl/u_cska24_acc_stage.sv
// Operand register stage feeding the 24-bit carry-skip adder, with an accumulate mode
// and a result FIFO on a valid/ready output stream.
module u_cska24_acc_stage
  import cska_stage_pkg::*;
#(
  parameter int WIDTH     = 24,
  parameter int OUT_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_op,
  output logic             out_ovf
);

  if (WIDTH != WIDTH_C) begin : gBadWidth
    $error("u_cska24_acc_stage: WIDTH must be 24");
  end
  if (OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : gBadDepth
    $error("u_cska24_acc_stage: OUT_DEPTH must be a power of two >= 2");
  end

  logic             s1Valid_q, s1Valid_d;
  logic             s1Op_q, s1Op_d;
  logic [WIDTH-1:0] s1A_q, s1A_d;
  logic [WIDTH-1:0] s1B_q, s1B_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] addB;
  logic [WIDTH:0]   sum;
  logic             fifoFull, fifoEmpty, pop, s1Fire, isAcc;
  res_t             resPush, resHead;

  assign pop      = !fifoEmpty && out_ready;
  assign s1Fire   = s1Valid_q && (!fifoFull || pop);
  assign in_ready = !rst && (!s1Valid_q || s1Fire);
  assign isAcc    = (s1Op_q == OP_ACC);
  assign addB     = isAcc ? acc_q : s1B_q;

  h_u_cska24 uAdder (
    .a  (s1A_q),
    .b  (addB),
    .out(sum)
  );

  // Result carries the pre-clear accumulator state even when acc_clr coincides with the fire.
  always_comb begin
    resPush.op  = s1Op_q;
    resPush.sum = sum;
    resPush.ovf = isAcc ? (ovf_q | sum[WIDTH]) : 1'b0;
  end

  always_comb begin
    s1Valid_d = in_ready ? in_valid : s1Valid_q;
    s1Op_d    = s1Op_q;
    s1A_d     = s1A_q;
    s1B_d     = s1B_q;
    if (in_ready && in_valid) begin
      s1Op_d = in_op;
      s1A_d  = in_a;
      s1B_d  = in_b;
    end
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (acc_clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (s1Fire && isAcc) begin
      acc_d = sum[WIDTH-1:0];
      ovf_d = resPush.ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s1Op_q    <= 1'b0;
      s1A_q     <= '0;
      s1B_q     <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s1Op_q    <= s1Op_d;
      s1A_q     <= s1A_d;
      s1B_q     <= s1B_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
    end
  end

  cska_res_fifo #(
    .DEPTH(OUT_DEPTH)
  ) uFifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (s1Fire),
    .push_data_i(resPush),
    .pop_i      (pop),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .pop_data_o (resHead)
  );

  // Outputs read as zero whenever no result is presented.
  assign out_valid = !fifoEmpty;
  assign out_sum   = out_valid ? resHead.sum : '0;
  assign out_op    = out_valid ? resHead.op : 1'b0;
  assign out_ovf   = out_valid ? resHead.ovf : 1'b0;

endmodule

// File: tb/tb_u_cska24_acc_stage.sv
// Scoreboard bench for u_cska24_acc_stage: expected results are queued at accept time
// from an arithmetic model and compared in order as the DUT emits them.
module tb_u_cska24_acc_stage;

  typedef struct packed {
    logic        op;
    logic        ovf;
    logic [24:0] sum;
  } expRes_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [23:0] in_a;
  logic [23:0] in_b;
  logic        acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_sum;
  logic        out_op;
  logic        out_ovf;

  expRes_t     sbQueue[$];
  int          testCount = 0;
  int          failCount = 0;
  bit          randReady = 0;
  bit          beat4Done = 0;
  logic [23:0] modelAcc;
  logic        modelOvf;

  u_cska24_acc_stage #(
    .WIDTH    (24),
    .OUT_DEPTH(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .acc_clr  (acc_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_op   (out_op),
    .out_ovf  (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    if (randReady) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic pushExpected(input logic op, input logic [23:0] a, input logic [23:0] b);
    expRes_t e;
    e.op = op;
    if (op == 1'b0) begin
      e.sum = {1'b0, a} + {1'b0, b};
      e.ovf = 1'b0;
    end else begin
      e.sum    = {1'b0, a} + {1'b0, modelAcc};
      modelOvf = modelOvf | e.sum[24];
      modelAcc = e.sum[23:0];
      e.ovf    = modelOvf;
    end
    sbQueue.push_back(e);
  endtask

  task automatic applyStimulus(input logic op, input logic [23:0] a, input logic [23:0] b);
    int waited = 0;
    bit done = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        pushExpected(op, a, b);
        done = 1;
      end else if (waited > 300) begin
        checkOutput("accept timeout", {31'b0, in_ready}, 32'h1);
        done = 1;
      end
      waited++;
      stepCycle();
    end
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sbQueue.size() != 0 && n < 500) begin
      stepCycle();
      n++;
    end
    checkOutput("drain", sbQueue.size(), 0);
  endtask

  task automatic pulseClear();
    acc_clr = 1'b1;
    stepCycle();
    acc_clr  = 1'b0;
    modelAcc = '0;
    modelOvf = 1'b0;
  endtask

  task automatic monitorLoop();
    expRes_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sbQueue.size() == 0) begin
          checkOutput("spurious out_valid", {31'b0, out_valid}, 32'h0);
        end else begin
          e = sbQueue.pop_front();
          checkOutput("result", {5'b0, out_op, out_ovf, out_sum}, {5'b0, e.op, e.ovf, e.sum});
        end
      end
    end
  endtask

  initial begin
    logic        op;
    logic [23:0] a, b;
    int          k;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 1'b0;
    in_a      = '0;
    in_b      = '0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;
    modelAcc  = '0;
    modelOvf  = 1'b0;

    fork
      monitorLoop();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset in_ready", {31'b0, in_ready}, 32'h0);
    checkOutput("reset out_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("reset out_sum", {7'b0, out_sum}, 32'h0);
    checkOutput("reset out_ovf", {31'b0, out_ovf}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post-reset in_ready", {31'b0, in_ready}, 32'h1);
    stepCycle();

    // Full-carry ADD and two-cycle latency
    applyStimulus(1'b0, 24'hFFFFFF, 24'h000001);
    @(negedge clk);
    checkOutput("latency cycle1 out_valid", {31'b0, out_valid}, 32'h0);
    stepCycle();
    @(negedge clk);
    checkOutput("latency cycle2 out_valid", {31'b0, out_valid}, 32'h1);
    checkOutput("latency cycle2 out_sum", {7'b0, out_sum}, 32'h1000000);
    stepCycle();
    waitDrain();

    // Accumulate with sticky overflow
    pulseClear();
    repeat (3) applyStimulus(1'b1, 24'h800000, 24'h0);
    waitDrain();

    // Back-pressure: FIFO full, S1 occupied, fourth beat held off
    out_ready = 1'b0;
    applyStimulus(1'b0, 24'h000010, 24'h000001);
    applyStimulus(1'b0, 24'h000020, 24'h000002);
    applyStimulus(1'b0, 24'h000030, 24'h000003);
    fork
      begin
        applyStimulus(1'b0, 24'h000040, 24'h000004);
        beat4Done = 1;
      end
    join_none
    repeat (3) begin
      @(negedge clk);
      checkOutput("stall in_ready", {31'b0, in_ready}, 32'h0);
      checkOutput("stall out_valid", {31'b0, out_valid}, 32'h1);
      stepCycle();
    end
    checkOutput("stall queued beats", sbQueue.size(), 3);
    out_ready = 1'b1;
    waitDrain();
    checkOutput("fourth beat accepted", {31'b0, beat4Done}, 32'h1);

    // acc_clr coinciding with an ACC fire
    pulseClear();
    applyStimulus(1'b1, 24'h000005, 24'h0);
    applyStimulus(1'b1, 24'h000003, 24'h0);
    acc_clr = 1'b1;
    stepCycle();
    acc_clr  = 1'b0;
    modelAcc = '0;
    modelOvf = 1'b0;
    applyStimulus(1'b1, 24'h000001, 24'h0);
    waitDrain();

    // Reset with S1 and FIFO occupied
    out_ready = 1'b0;
    applyStimulus(1'b1, 24'h000123, 24'h0);
    applyStimulus(1'b0, 24'h000777, 24'h000111);
    applyStimulus(1'b0, 24'h000888, 24'h000222);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid-reset in_ready", {31'b0, in_ready}, 32'h0);
    stepCycle();
    rst = 1'b0;
    sbQueue.delete();
    modelAcc  = '0;
    modelOvf  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("after reset out_valid", {31'b0, out_valid}, 32'h0);
    stepCycle();
    applyStimulus(1'b0, 24'h000002, 24'h000003);
    applyStimulus(1'b1, 24'h000007, 24'h0);
    waitDrain();

    // Random traffic with random back-pressure and forced skip-chain nibbles
    randReady = 1;
    for (int i = 0; i < 10000; i++) begin
      op = 1'($urandom_range(0, 1));
      a  = 24'($urandom());
      b  = 24'($urandom());
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, 5);
        b[k*4 +: 4] = ~a[k*4 +: 4];
      end
      if ($urandom_range(0, 15) == 0) begin
        a = 24'hFFFFFF;
        b = 24'h000001;
      end
      applyStimulus(op, a, b);
      if ($urandom_range(0, 7) == 0) stepCycle();
      if ((i % 2000) == 1999) begin
        randReady = 0;
        out_ready = 1'b1;
        waitDrain();
        pulseClear();
        randReady = 1;
      end
    end
    randReady = 0;
    out_ready = 1'b1;
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
